// File: rtl/header_link_pkg.sv
// Shared UART definitions for header_link: bit-period helper, FSM state
// encoding and frame geometry used by both receive and transmit paths.
package header_link_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/header_link_uart_rx_byte.sv
// Single-byte UART receiver: two-flop synchroniser, mid-bit sampling FSM,
// byte_valid on a good stop bit and stop_error on a bad one.
module uart_rx_byte
  import header_link_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_rxd,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_stop_error,
  output logic       o_busy
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);

  logic          r_sync1;
  logic          r_sync2;
  uart_state_t   r_state;
  uart_state_t   w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_next;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic          r_armed;
  logic          w_armed_next;
  logic          w_byte_valid;
  logic          w_stop_error;
  logic          r_byte_valid;
  logic          r_stop_error;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_armed      <= 1'b0;
      r_byte_valid <= 1'b0;
      r_stop_error <= 1'b0;
    end else begin
      r_sync1      <= i_rxd;
      r_sync2      <= r_sync1;
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_bit        <= w_bit_next;
      r_shift      <= w_shift_next;
      r_armed      <= w_armed_next;
      r_byte_valid <= w_byte_valid;
      r_stop_error <= w_stop_error;
    end
  end

  // r_armed blocks a new start until the line has been seen idle (high),
  // so a held break after a framing error is not decoded as bytes.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_armed_next = r_armed;
    w_byte_valid = 1'b0;
    w_stop_error = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (r_sync2) begin
          w_armed_next = 1'b1;
        end else if (r_armed) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next   = '0;
          w_bit_next   = '0;
          w_state_next = r_sync2 ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = '0;
          w_shift_next = {r_sync2, r_shift[7:1]};
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == 3'(DATA_BITS - 1)) begin
            w_state_next = ST_STOP;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
          if (r_sync2) begin
            w_byte_valid = 1'b1;
          end else begin
            w_stop_error = 1'b1;
            w_armed_next = 1'b0;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_stop_error = r_stop_error;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: rtl/header_link.sv
// Host UART framing: assembles fixed-length block headers from the serial
// link and serialises found nonces back, MSB byte first.
module header_link
  import header_link_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int HEADER_BYTES = 80,
  parameter int NONCE_BYTES  = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                                i_clock,
  input  logic                                i_reset_n,
  input  logic                                i_rxd,
  output logic                                o_txd,
  output logic [8*HEADER_BYTES-1:0]           o_header,
  output logic                                o_header_valid,
  output logic                                o_frame_error,
  output logic [$clog2(HEADER_BYTES+1)-1:0]   o_rx_count,
  input  logic [8*NONCE_BYTES-1:0]            i_nonce,
  input  logic                                i_nonce_send,
  output logic                                o_tx_busy
);

  localparam int DIV       = calc_div(CLK_HZ, BAUD);
  localparam int HB        = 8 * HEADER_BYTES;
  localparam int NB        = 8 * NONCE_BYTES;
  localparam int RCW       = $clog2(HEADER_BYTES + 1);
  localparam int TO_CYCLES = TIMEOUT_BITS * DIV;
  localparam int TCW       = $clog2(TO_CYCLES + 1);
  localparam int CW        = $clog2(DIV);
  localparam int BCW       = $clog2(NONCE_BYTES + 1);
  localparam logic [RCW-1:0] RX_LAST  = RCW'(HEADER_BYTES - 1);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TO_CYCLES - 1);
  localparam logic [CW-1:0]  BIT_LAST = CW'(DIV - 1);

  logic [7:0] w_rx_byte;
  logic       w_byte_valid;
  logic       w_stop_error;
  logic       w_rx_busy;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_rxd        (i_rxd),
    .o_byte       (w_rx_byte),
    .o_byte_valid (w_byte_valid),
    .o_stop_error (w_stop_error),
    .o_busy       (w_rx_busy)
  );

  logic [HB-1:0]  r_assembly;
  logic [HB-1:0]  r_header;
  logic [RCW-1:0] r_rx_count;
  logic [TCW-1:0] r_idle_cnt;
  logic           r_header_valid;
  logic           r_frame_error;

  // Idle counter is preloaded to 1 on byte acceptance so the timeout pulse
  // lands exactly TO_CYCLES after the stop-bit sample.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_assembly     <= '0;
      r_header       <= '0;
      r_rx_count     <= '0;
      r_idle_cnt     <= '0;
      r_header_valid <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_header_valid <= 1'b0;
      r_frame_error  <= 1'b0;
      if (w_stop_error) begin
        r_assembly    <= '0;
        r_rx_count    <= '0;
        r_idle_cnt    <= '0;
        r_frame_error <= 1'b1;
      end else if (w_byte_valid) begin
        r_idle_cnt <= TCW'(1);
        if (r_rx_count == RX_LAST) begin
          r_header       <= {r_assembly[HB-9:0], w_rx_byte};
          r_header_valid <= 1'b1;
          r_assembly     <= '0;
          r_rx_count     <= '0;
        end else begin
          r_assembly <= {r_assembly[HB-9:0], w_rx_byte};
          r_rx_count <= r_rx_count + RCW'(1);
        end
      end else if (w_rx_busy || (r_rx_count == '0)) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt == TO_LAST) begin
        r_assembly    <= '0;
        r_rx_count    <= '0;
        r_idle_cnt    <= '0;
        r_frame_error <= 1'b1;
      end else begin
        r_idle_cnt <= r_idle_cnt + TCW'(1);
      end
    end
  end

  assign o_header       = r_header;
  assign o_header_valid = r_header_valid;
  assign o_frame_error  = r_frame_error;
  assign o_rx_count     = r_rx_count;

  uart_state_t   r_tx_state;
  uart_state_t   w_tx_state_next;
  logic [CW-1:0] r_tx_cnt;
  logic [CW-1:0] w_tx_cnt_next;
  logic [3:0]    r_tx_bit;
  logic [3:0]    w_tx_bit_next;
  logic [BCW-1:0] r_tx_byte_idx;
  logic [BCW-1:0] w_tx_byte_idx_next;
  logic [NB-1:0] r_tx_shift;
  logic [NB-1:0] w_tx_shift_next;
  logic          r_txd;
  logic          w_txd_next;
  logic          r_tx_busy;
  logic          w_tx_busy_next;
  logic [7:0]    w_tx_cur;

  assign w_tx_cur = r_tx_shift[NB-1 -: 8];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx_state    <= ST_IDLE;
      r_tx_cnt      <= '0;
      r_tx_bit      <= '0;
      r_tx_byte_idx <= '0;
      r_tx_shift    <= '0;
      r_txd         <= 1'b1;
      r_tx_busy     <= 1'b0;
    end else begin
      r_tx_state    <= w_tx_state_next;
      r_tx_cnt      <= w_tx_cnt_next;
      r_tx_bit      <= w_tx_bit_next;
      r_tx_byte_idx <= w_tx_byte_idx_next;
      r_tx_shift    <= w_tx_shift_next;
      r_txd         <= w_txd_next;
      r_tx_busy     <= w_tx_busy_next;
    end
  end

  // r_tx_bit indexes the frame: 0 = start, 1..8 = data, 9 = stop.
  always_comb begin
    w_tx_state_next    = r_tx_state;
    w_tx_cnt_next      = r_tx_cnt;
    w_tx_bit_next      = r_tx_bit;
    w_tx_byte_idx_next = r_tx_byte_idx;
    w_tx_shift_next    = r_tx_shift;
    w_txd_next         = r_txd;
    w_tx_busy_next     = r_tx_busy;
    if (r_tx_state == ST_IDLE) begin
      w_txd_next     = 1'b1;
      w_tx_busy_next = 1'b0;
      if (i_nonce_send) begin
        w_tx_state_next    = ST_START;
        w_tx_shift_next    = i_nonce;
        w_tx_cnt_next      = '0;
        w_tx_bit_next      = '0;
        w_tx_byte_idx_next = '0;
        w_txd_next         = 1'b0;
        w_tx_busy_next     = 1'b1;
      end
    end else if (r_tx_cnt != BIT_LAST) begin
      w_tx_cnt_next = r_tx_cnt + CW'(1);
    end else begin
      w_tx_cnt_next = '0;
      w_tx_bit_next = r_tx_bit + 4'd1;
      case (r_tx_state)
        ST_START: begin
          w_tx_state_next = ST_DATA;
          w_txd_next      = w_tx_cur[0];
        end
        ST_DATA: begin
          if (r_tx_bit == 4'(FRAME_BITS - 2)) begin
            w_tx_state_next = ST_STOP;
            w_txd_next      = 1'b1;
          end else begin
            w_txd_next = w_tx_cur[r_tx_bit[2:0]];
          end
        end
        ST_STOP: begin
          w_tx_bit_next = '0;
          if (r_tx_byte_idx == BCW'(NONCE_BYTES - 1)) begin
            w_tx_state_next = ST_IDLE;
            w_tx_busy_next  = 1'b0;
          end else begin
            w_tx_state_next    = ST_START;
            w_tx_byte_idx_next = r_tx_byte_idx + BCW'(1);
            w_tx_shift_next    = {r_tx_shift[NB-9:0], 8'h00};
            w_txd_next         = 1'b0;
          end
        end
        default: w_tx_state_next = ST_IDLE;
      endcase
    end
  end

  assign o_txd     = r_txd;
  assign o_tx_busy = r_tx_busy;

endmodule

// File: doc/header_link.md
# header_link

Parametrised UART framing block between the host serial link and the mining core. It receives a fixed-length block header byte-by-byte and publishes it as one wide, double-buffered word with a valid strobe. It transmits a found nonce back to the host on request. Compared with a fixed-width serial core, it adds configurable header and nonce lengths, baud rate, framing-error and inter-byte-timeout recovery, and a transmit busy handshake.

## Interface
**Parameters**
- CLK_HZ, 50_000_000, core clock frequency
- BAUD, 115200, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD cycles per bit, DIV ≥ 4
- HEADER_BYTES, 80, bytes per received frame; HB = 8·HEADER_BYTES
- NONCE_BYTES, 4, bytes per transmitted nonce; NB = 8·NONCE_BYTES
- TIMEOUT_BITS, 20, idle bit-periods mid-frame before the partial frame is discarded

**Ports**
- clock  in  1  single core clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- rxd  in  1  serial input, asynchronous, idle high
- txd  out  1  serial output, idle high
- header  out  HB  last complete frame; first byte received in [HB-1:HB-8]
- header_valid  out  1  one-cycle pulse when header updates
- frame_error  out  1  one-cycle pulse on bad stop bit or timeout
- rx_count  out  $clog2(HEADER_BYTES+1)  bytes of current partial frame
- nonce  in  NB  nonce to send; transmitted MSB byte first
- nonce_send  in  1  request; sampled only while tx_busy=0
- tx_busy  out  1  high from the cycle after an accepted request until the end of the last stop bit

## Operation
- **Reset values:** txd=1, tx_busy=0, header=0, header_valid=0, frame_error=0, rx_count=0. Both FSMs return to IDLE.
- **RX synchroniser:** rxd passes through 2 flops before any use.
- **RX FSM** (IDLE → START → DATA → STOP):
  - IDLE: a falling edge on the synchronised rxd starts a bit counter and enters START.
  - START: re-sample at DIV/2. If the line is high, treat as a glitch and return to IDLE.
  - DATA: sample 8 bits, LSB first, every DIV cycles.
  - STOP: sample after DIV more cycles.
- **Byte acceptance:**
  - Stop = 1: the byte shifts into the assembly register and rx_count increments.
  - Stop = 0: discard the byte, clear the assembly register and rx_count, pulse frame_error, and return to IDLE. The next falling edge is only honoured after rxd has been seen high.
- **Frame completion:** when rx_count would reach HEADER_BYTES, copy the assembly register to header in the same cycle, pulse header_valid, and reset rx_count to 0. header changes only on completion.
- **Inter-byte timeout:** when rx_count > 0, an idle counter runs in IDLE. After TIMEOUT_BITS·DIV cycles with no start bit, clear the partial frame and pulse frame_error. The timeout never fires when rx_count = 0.
- **Simultaneous errors:** a timeout and a stop-bit error cannot coincide, so only one frame_error pulse is ever generated per abort.
- **TX FSM** (IDLE → START → DATA → STOP, repeated NONCE_BYTES times):
  - In IDLE, nonce_send=1 latches nonce into a shift register.
  - Each byte is sent as start 0, 8 data bits LSB first, stop 1. There is no gap between bytes.
  - nonce_send while tx_busy=1 is ignored; it is not queued.
- **Independence:** RX and TX are fully independent, so full duplex is supported.

## Timing
- **TX latency:** txd falls 1 cycle after the accepted nonce_send. Each bit lasts exactly DIV cycles.
- **tx_busy:** high for exactly 10·DIV·NONCE_BYTES cycles. A new request is accepted in the cycle tx_busy returns low.
- **RX latency:**
  - header_valid fires 1 cycle after the stop-bit sample of the final byte.
  - The stop sample is taken 2 (synchroniser) + DIV/2 + 9·DIV cycles after the rxd falling edge.
- **Mid-operation reset:** reset asserted during any transfer clears everything asynchronously. txd returns to 1 immediately and the partial frame is lost.

## Structure
- **Shared package (header_link_pkg):**
  - Function computing DIV
  - RX/TX state enum (IDLE, START, DATA, STOP)
  - UART frame constants: 8 data bits, 10 bits per frame
- **Sub-module uart_rx_byte:** synchroniser, RX FSM and bit timer. Outputs a byte, a byte_valid pulse and a stop_error pulse.
- **Top level:** assembly register, rx_count, timeout and the TX FSM stay in the top level; TX is small enough to stay inline.

## Test plan
Run with CLK_HZ=50_000_000 and BAUD=5_000_000 (DIV=10).
1. **Full frame:** send 80 bytes 0x00..0x4F back-to-back → exactly one header_valid pulse, header[639:632]=0x00, header[7:0]=0x4F, rx_count=0 afterwards.
2. **Nonce transmit:** nonce=0x12345678 with a one-cycle nonce_send → txd carries bytes 0x12, 0x34, 0x56, 0x78 at 10 cycles/bit; tx_busy high for 400 cycles; a second nonce_send at cycle 200 produces no extra bytes.
3. **Bad stop bit:** byte 5 sent with stop=0 → one frame_error pulse, rx_count=0, header keeps its previous value; the next 80 good bytes complete normally.
4. **Timeout:** 10 bytes, then idle for 200 cycles → frame_error exactly once at 200 cycles after the last stop sample, rx_count=0. Idle with rx_count=0 → no pulse.
5. **Glitch rejection:** a 3-cycle low pulse on rxd → no byte is accepted and rx_count is unchanged.
6. **Reset mid-transfer:** reset asserted at byte 40 during TX → txd=1, tx_busy=0, rx_count=0 immediately; after release, a full 80-byte frame decodes correctly.
